// File: rtl/mem_core_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : mem_core_frame_sched
// Purpose  : Frame sequencer for a double-buffered memory core. Admits one
//            frame of writes ahead of the frame being read, issues credit-
//            limited reads and buffers the core's returned words for a
//            backpressured consumer.
// Revision : 1.0  initial release
// ============================================================================
module mem_core_frame_sched #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int OBUF_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  cfg_depth,
  input  logic [CNT_WIDTH-1:0]  cfg_reads,
  input  logic [CNT_WIDTH-1:0]  cfg_frames,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  core_wen,
  output logic [DATA_WIDTH-1:0] core_data_in,
  output logic                  core_ren,
  input  logic                  core_valid_out,
  input  logic [DATA_WIDTH-1:0] core_data_out,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  job_done,
  output logic                  cfg_err
);

  localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int CW = $clog2(OBUF_DEPTH + 1);
  localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic [CNT_WIDTH-1:0]  r_depth;
  logic [CNT_WIDTH-1:0]  r_reads;
  logic [CNT_WIDTH-1:0]  r_frames;
  logic [CNT_WIDTH-1:0]  r_wr_cnt;
  logic [CNT_WIDTH-1:0]  r_wr_frame;
  logic [CNT_WIDTH-1:0]  r_rd_cnt;
  logic                  r_cfg_err;

  logic [CW-1:0]         r_inflight;
  logic [CW-1:0]         r_occ;
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [DATA_WIDTH-1:0] r_mem [OBUF_DEPTH];

  logic                  w_in_ready_raw;
  logic                  w_start_idle;
  logic                  w_cfg_zero;
  logic                  w_accept;
  logic                  w_wr_last;
  logic                  w_wr_full;
  logic                  w_reading;
  logic                  w_credit_ok;
  logic                  w_ren;
  logic                  w_rd_done;
  logic                  w_swap;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_drain_done;
  logic [CNT_WIDTH-1:0]  w_wr_frame_inc;

  assign w_start_idle   = start && (r_state == ST_IDLE);
  assign w_cfg_zero     = (cfg_depth == '0) || (cfg_reads == '0) || (cfg_frames == '0);
  assign w_accept       = clk_en && in_valid && w_in_ready_raw;
  assign w_wr_last      = w_accept && (r_wr_cnt == (r_depth - C_ONE));
  assign w_wr_full      = (r_wr_cnt == r_depth) || w_wr_last;
  assign w_reading      = (r_state == ST_STREAM) || (r_state == ST_DRAIN);
  // Stored words plus outstanding reads must leave room for every return,
  // because the core cannot be stalled once a read is issued.
  assign w_credit_ok    = ({1'b0, r_occ} + {1'b0, r_inflight}) < (CW+1)'(OBUF_DEPTH);
  assign w_ren          = clk_en && w_reading && (r_rd_cnt < r_reads) && w_credit_ok;
  assign w_rd_done      = (r_rd_cnt == r_reads) || (w_ren && (r_rd_cnt == (r_reads - C_ONE)));
  assign w_swap         = (r_state == ST_STREAM) && w_rd_done && w_wr_full;
  assign w_wr_frame_inc = r_wr_frame + C_ONE;
  // Returns that arrive with no read outstanding are stale (pre-reset) and dropped.
  assign w_push         = clk_en && core_valid_out && (r_inflight != '0);
  assign w_pop          = out_valid && out_ready;
  assign w_drain_done   = clk_en && (r_state == ST_DRAIN) && (r_rd_cnt == r_reads) &&
                          (r_inflight == '0) && (r_occ == '0);

  assign in_ready     = clk_en && w_in_ready_raw;
  assign core_wen     = w_accept;
  assign core_data_in = in_data;
  assign core_ren     = w_ren;
  assign out_valid    = clk_en && (r_occ != '0);
  assign out_data     = r_mem[r_rptr];
  assign busy         = (r_state != ST_IDLE);
  assign job_done     = w_drain_done;
  assign cfg_err      = r_cfg_err;

  // Next-state and write-window decode.
  always_comb begin
    w_next_state   = r_state;
    w_in_ready_raw = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !w_cfg_zero) w_next_state = ST_FILL;
      end
      ST_FILL: begin
        w_in_ready_raw = 1'b1;
        if (w_wr_last) w_next_state = (r_frames > C_ONE) ? ST_STREAM : ST_DRAIN;
      end
      ST_STREAM: begin
        w_in_ready_raw = (r_wr_cnt < r_depth) && (r_wr_frame < r_frames);
        if (w_swap && (w_wr_frame_inc == r_frames)) w_next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_drain_done) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register, config shadows and frame counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_depth    <= '0;
      r_reads    <= '0;
      r_frames   <= '0;
      r_wr_cnt   <= '0;
      r_wr_frame <= '0;
      r_rd_cnt   <= '0;
      r_cfg_err  <= 1'b0;
    end else if (clk_en) begin
      r_state   <= w_next_state;
      r_cfg_err <= w_start_idle && w_cfg_zero;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_depth    <= cfg_depth;
            r_reads    <= cfg_reads;
            r_frames   <= cfg_frames;
            r_wr_cnt   <= '0;
            r_wr_frame <= '0;
            r_rd_cnt   <= '0;
          end
        end
        ST_FILL: begin
          if (w_wr_last) begin
            r_wr_cnt   <= '0;
            r_wr_frame <= C_ONE;
          end else if (w_accept) begin
            r_wr_cnt <= r_wr_cnt + C_ONE;
          end
        end
        ST_STREAM: begin
          if (w_swap) begin
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
            r_wr_frame <= w_wr_frame_inc;
          end else begin
            if (w_accept) r_wr_cnt <= r_wr_cnt + C_ONE;
            if (w_ren)    r_rd_cnt <= r_rd_cnt + C_ONE;
          end
        end
        ST_DRAIN: begin
          if (w_ren) r_rd_cnt <= r_rd_cnt + C_ONE;
        end
        default: ;
      endcase
    end
  end

  // Output buffer bookkeeping: pointers, occupancy and reads in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inflight <= '0;
      r_occ      <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else if (clk_en) begin
      r_inflight <= r_inflight + CW'(w_ren) - CW'(w_push);
      r_occ      <= r_occ + CW'(w_push) - CW'(w_pop);
      if (w_push) r_wptr <= (r_wptr == PW'(OBUF_DEPTH - 1)) ? '0 : r_wptr + PW'(1);
      if (w_pop)  r_rptr <= (r_rptr == PW'(OBUF_DEPTH - 1)) ? '0 : r_rptr + PW'(1);
    end
  end

  // Output buffer storage; contents are qualified by occupancy, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= core_data_out;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_core_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_core_frame_sched
// Purpose  : Directed self-checking bench for mem_core_frame_sched with a
//            one-cycle-latency core responder returning 16'hA000 + read index.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_core_frame_sched;

  logic        clk = 1'b0;
  logic        reset, clk_en, start;
  logic [15:0] cfg_depth, cfg_reads, cfg_frames;
  logic        in_valid, in_ready, core_wen, core_ren, core_valid_out;
  logic [15:0] in_data, core_data_in, core_data_out, out_data;
  logic        out_valid, out_ready, busy, job_done, cfg_err;
  logic [15:0] ridx;

  int checks = 0;
  int failures = 0;

  // Monitor state
  int cyc = 0, wen_total = 0, ren_total = 0, done_total = 0, err_total = 0;
  int en_viol = 0, din_bad = 0, overlap_total = 0, occ_m = 0, max_occ = 0;
  int max_ahead = -1000, wen_at_first_ren = -1, busy_at_done = 0;
  logic [15:0] q[$];

  // Bench-owned snapshot state
  int wen_base = 0, ren_base = 0, done_base = 0, ov_base = 0, err_base = 0, qb = 0;
  int depth_cur = 1, reads_cur = 1;
  bit track_ahead = 1'b0;
  int ahead_now;
  int dur_a, dur_b, dummy, n;

  assign ahead_now = track_ahead ?
    ((wen_total - wen_base) - depth_cur * (((ren_total - ren_base) / reads_cur) + 1)) : -1000;

  mem_core_frame_sched #(.DATA_WIDTH(16), .CNT_WIDTH(16), .OBUF_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
    .cfg_depth(cfg_depth), .cfg_reads(cfg_reads), .cfg_frames(cfg_frames),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .core_wen(core_wen), .core_data_in(core_data_in), .core_ren(core_ren),
    .core_valid_out(core_valid_out), .core_data_out(core_data_out),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .job_done(job_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Core model: one-cycle read latency, frozen with clk_en.
  always @(posedge clk) begin
    if (reset) begin
      core_valid_out <= 1'b0;
      core_data_out  <= 16'h0;
      ridx           <= 16'h0;
    end else if (clk_en) begin
      core_valid_out <= core_ren;
      if (core_ren) begin
        core_data_out <= 16'hA000 + ridx;
        ridx          <= ridx + 16'h1;
      end
    end
  end

  // Observation away from the active edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (reset) occ_m <= 0;
    else occ_m <= occ_m + ((clk_en && core_valid_out) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
    if (occ_m > max_occ) max_occ <= occ_m;
    if (core_wen) wen_total <= wen_total + 1;
    if (core_wen && (core_data_in !== in_data)) din_bad <= din_bad + 1;
    if (core_wen && (ren_total != ren_base)) overlap_total <= overlap_total + 1;
    if (core_ren) ren_total <= ren_total + 1;
    if (core_ren && (ren_total == ren_base)) wen_at_first_ren <= wen_total - wen_base;
    if (out_valid && out_ready) q.push_back(out_data);
    if (job_done) begin
      done_total   <= done_total + 1;
      busy_at_done <= busy ? 1 : 0;
    end
    if (cfg_err) err_total <= err_total + 1;
    if (!clk_en && (in_ready || core_wen || core_ren || out_valid)) en_viol <= en_viol + 1;
    if (!track_ahead) max_ahead <= -1000;
    else if (ahead_now > max_ahead) max_ahead <= ahead_now;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    wen_base  = wen_total;
    ren_base  = ren_total;
    done_base = done_total;
    ov_base   = overlap_total;
    err_base  = err_total;
    qb        = q.size();
  endtask

  task automatic do_start(input logic [15:0] d, input logic [15:0] r, input logic [15:0] f);
    cfg_depth  = d;
    cfg_reads  = r;
    cfg_frames = f;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit toggle, output int cycles);
    int d0;
    d0 = done_total;
    cycles = 0;
    while ((done_total == d0) && (cycles < budget)) begin
      @(posedge clk); #1;
      cycles++;
      if (toggle) clk_en = ~clk_en;
    end
    clk_en = 1'b1;
    chk("job_done_timeout", (done_total != d0), 1);
  endtask

  task automatic chk_data(input string tag, input int count, input logic [15:0] base);
    logic [15:0] obs;
    for (int i = 0; i < count; i++) begin
      obs = (qb + i < q.size()) ? q[qb + i] : 16'hDEAD;
      chk($sformatf("%s[%0d]", tag, i), {16'h0, obs}, {16'h0, base + 16'(i)});
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clk_en = 1'b1; start = 1'b0;
    cfg_depth = 16'h0; cfg_reads = 16'h0; cfg_frames = 16'h0;
    in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("reset_outputs", {25'h0, busy, in_ready, core_wen, core_ren, out_valid, job_done, cfg_err}, 0);
    reset = 1'b0; in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("idle_no_ready", {30'h0, in_ready, busy}, 0);

    // Single frame: writes strictly before reads.
    snap();
    do_start(16'd4, 16'd4, 16'd1);
    wait_done(300, 1'b0, dummy);
    chk("t1_busy_after_done", {31'h0, busy}, 0);
    chk("t1_busy_at_done", busy_at_done, 1);
    chk("t1_writes", wen_total - wen_base, 4);
    chk("t1_reads", ren_total - ren_base, 4);
    chk("t1_writes_before_first_read", wen_at_first_ren, 4);
    chk("t1_no_overlap", overlap_total - ov_base, 0);
    chk("t1_out_count", q.size() - qb, 4);
    chk_data("t1_data", 4, 16'hA000);
    repeat (3) @(posedge clk); #1;
    chk("t1_done_once", done_total - done_base, 1);

    // Three frames, overlapped write/read.
    snap();
    depth_cur = 3; reads_cur = 12; track_ahead = 1'b1;
    do_start(16'd3, 16'd12, 16'd3);
    wait_done(2000, 1'b0, dummy);
    chk("t2_max_ahead", max_ahead, 3);
    track_ahead = 1'b0;
    chk("t2_writes", wen_total - wen_base, 9);
    chk("t2_reads", ren_total - ren_base, 36);
    chk("t2_first_frame_full", wen_at_first_ren, 3);
    chk("t2_overlap_seen", (overlap_total - ov_base) > 0, 1);
    chk("t2_out_count", q.size() - qb, 36);
    chk_data("t2_data", 36, 16'hA004);
    repeat (2) @(posedge clk); #1;
    chk("t2_done_once", done_total - done_base, 1);

    // Consumer stall mid-read.
    snap();
    do_start(16'd2, 16'd8, 16'd1);
    n = 0;
    while ((q.size() < qb + 2) && (n < 100)) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t3_reach_stall_timeout", (q.size() >= qb + 2), 1);
    out_ready = 1'b0;
    n = ren_total;
    dummy = q.size();
    repeat (10) @(posedge clk); #1;
    chk("t3_stall_ren_off", {31'h0, core_ren}, 0);
    chk("t3_stall_out_valid", {31'h0, out_valid}, 1);
    chk("t3_stall_issue_bound", (ren_total - n) <= 2, 1);
    chk("t3_stall_no_pop", q.size(), dummy);
    chk("t3_obuf_bound", max_occ <= 2, 1);
    out_ready = 1'b1;
    wait_done(300, 1'b0, dummy);
    chk("t3_out_count", q.size() - qb, 8);
    chk_data("t3_data", 8, 16'hA028);

    // Zero depth rejected.
    snap();
    cfg_depth = 16'd0; cfg_reads = 16'd4; cfg_frames = 16'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t4_cfg_err_pulse", {31'h0, cfg_err}, 1);
    chk("t4_busy_low", {31'h0, busy}, 0);
    @(posedge clk); #1;
    chk("t4_cfg_err_cleared", {30'h0, cfg_err, busy}, 0);
    repeat (4) @(posedge clk); #1;
    chk("t4_no_core_access", (wen_total - wen_base) + (ren_total - ren_base), 0);
    chk("t4_err_once", err_total - err_base, 1);

    // Reference run, then the same job with clk_en toggling.
    snap();
    do_start(16'd3, 16'd6, 16'd2);
    wait_done(1000, 1'b0, dur_a);
    chk("t5a_out_count", q.size() - qb, 12);
    chk_data("t5a_data", 12, 16'hA030);
    snap();
    do_start(16'd3, 16'd6, 16'd2);
    wait_done(2000, 1'b1, dur_b);
    chk("t5b_out_count", q.size() - qb, 12);
    chk_data("t5b_data", 12, 16'hA03C);
    chk("t5b_duration", dur_b, 2 * dur_a - 1);
    chk("t5b_no_handshake_when_frozen", en_viol, 0);
    chk("t5b_done_once", done_total - done_base, 1);

    // Reset mid-STREAM, then a fresh short job.
    snap();
    do_start(16'd3, 16'd6, 16'd3);
    n = 0;
    while (((ren_total - ren_base) < 8) && (n < 200)) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_reach_stream_timeout", (ren_total - ren_base) >= 8, 1);
    chk("t6_busy_mid_job", {31'h0, busy}, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t6_reset_outputs", {25'h0, busy, in_ready, core_wen, core_ren, out_valid, job_done, cfg_err}, 0);
    reset = 1'b0;
    snap();
    do_start(16'd2, 16'd2, 16'd1);
    wait_done(300, 1'b0, dummy);
    chk("t6_writes", wen_total - wen_base, 2);
    chk("t6_reads", ren_total - ren_base, 2);
    chk("t6_out_count", q.size() - qb, 2);
    chk_data("t6_data", 2, 16'hA000);
    repeat (2) @(posedge clk); #1;
    chk("t6_done_once", done_total - done_base, 1);

    chk("final_obuf_bound", max_occ <= 2, 1);
    chk("final_write_passthrough", din_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_core_frame_sched.md
Name: mem_core_frame_sched

Overview:
Sequences a memory_core instance running in double-buffer mode: admits a write stream of cfg_depth words per frame, then issues cfg_reads read requests per frame. Writes of frame N+1 overlap reads of frame N. Reads are credit-limited so the core's un-backpressurable valid_out never overflows the downstream consumer. Sits between the producer/consumer streams and the core's wen_in/ren_in/data ports, replacing the bench-level counting constraints with enforced hardware sequencing.

Parameters:
DATA_WIDTH, 16, data word width
CNT_WIDTH, 16, width of depth/read/frame counters
OBUF_DEPTH, 2, output buffer entries; must be >= core read latency + 1

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
clk_en  input  1  global enable; 0 freezes all state
start  input  1  pulse; starts a job when in IDLE
cfg_depth  input  CNT_WIDTH  words written per frame
cfg_reads  input  CNT_WIDTH  reads issued per frame
cfg_frames  input  CNT_WIDTH  frames per job
in_valid  input  1  producer word valid
in_data  input  DATA_WIDTH  producer word
in_ready  output  1  producer handshake
core_wen  output  1  to core wen_in
core_data_in  output  DATA_WIDTH  to core data_in
core_ren  output  1  to core ren_in
core_valid_out  input  1  from core valid_out
core_data_out  input  DATA_WIDTH  from core data_out
out_valid  output  1  consumer word valid
out_data  output  DATA_WIDTH  consumer word
out_ready  input  1  consumer handshake
busy  output  1  state != IDLE
job_done  output  1  one-cycle pulse at job completion
cfg_err  output  1  one-cycle pulse: start rejected

Behaviour:
- Interface: single clock clk; reset synchronous, active-high. Reset values: state=IDLE, all counters 0, OBUF empty, in_ready=0, core_wen=0, core_ren=0, out_valid=0, busy=0, job_done=0, cfg_err=0.
- Reset mid-job aborts immediately; OBUF contents and in-flight reads discarded.
- clk_en=0: no state, counter or OBUF update; in_ready, core_wen, core_ren and out_valid forced 0.
- IDLE: on start, latch cfg_* into shadow registers. If any cfg value is 0: pulse cfg_err next cycle and stay IDLE. Otherwise go to FILL. start outside IDLE is ignored.
- Write side: in_ready=1 in FILL, and in STREAM while wr_cnt<depth and wr_frame<frames. Accept = in_valid & in_ready. core_wen=accept; core_data_in=in_data (combinational pass-through). wr_cnt increments on accept.
- FILL: writes only. When the accept that makes wr_cnt==depth occurs: wr_cnt<=0, wr_frame<=1. Then go to STREAM if frames>1, else DRAIN.
- Read side (STREAM, DRAIN): issue core_ren=1 iff rd_cnt<reads and (OBUF occupancy + in-flight reads) < OBUF_DEPTH. rd_cnt increments on issue.
- core_valid_out pushes core_data_out into OBUF; it is never dropped (guaranteed by the credit rule). out_valid = OBUF non-empty; out_data = OBUF head. Pop on out_valid & out_ready. A push and pop in the same cycle are both honoured.
- STREAM frame swap: a read frame completes when rd_cnt==reads. At that point, if the next write frame is full (wr_cnt==depth, or the final write is accepted this cycle): rd_cnt<=0, wr_cnt<=0, wr_frame++. Reads stall at rd_cnt==reads until the write frame is full. Writes stall at wr_cnt==depth until the read frame completes. Last write and last read in the same cycle swap in that cycle.
- On a swap with wr_frame reaching frames: go to DRAIN (writes closed).
- DRAIN: reads only. When rd_cnt==reads, no reads are in flight and OBUF is empty: pulse job_done and return to IDLE.
- Invariant: words written minus words read-frames never exceeds one frame (depth) ahead.
- Counters are CNT_WIDTH-bit unsigned; all comparisons are equality/less-than on the latched shadow values; no wrap occurs within legal config.

Test Plan:
- depth=4, reads=4, frames=1, in_valid and out_ready held 1 -> 4 core_wen cycles, then 4 core_ren; 4 outputs equal to the core return data; job_done exactly once; busy drops the cycle after.
- depth=3, reads=12, frames=3, continuous traffic -> writes of frame 2 overlap reads of frame 1; never more than 3 writes ahead of read-frame completion; 36 outputs; single job_done.
- out_ready=0 for 10 cycles mid-read -> core_ren deasserts once occupancy+in-flight==2; no OBUF overflow; out_data sequence intact after release.
- cfg_depth=0 with start -> cfg_err pulse, busy stays 0, no core_wen/core_ren.
- clk_en toggled 1/0 every cycle during STREAM -> identical output sequence to clk_en=1, with twice the duration; no handshakes while clk_en=0.
- reset asserted mid-STREAM, then a new start with depth=2, frames=1 -> outputs return to reset values next cycle; new job completes cleanly with 2 writes and job_done.
